// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the multicycle Div and Mult units.
// Latches the operands, issues one start pulse, qualifies completion, and commits or flags.
module muldiv_ctrl #(
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        div_start,
    output logic        mult_start,
    input  logic        div_finished,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo
);

    localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 1) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_EXC   = 3'd5;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             to_flag;
    logic             qualified;
    logic             expire;

    // The unit's flag is ignored for the first SETTLE WAIT cycles; Div's flag can be stale high.
    assign qualified = (wait_cnt >= CNT_W'(SETTLE)) &&
                       ((op_q == OP_DIV) ? div_finished : mult_done);
    assign expire    = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (op[1])
                        state_nxt = ST_WRITE;
                    else if (op == OP_DIV && op_b == 32'd0)
                        state_nxt = ST_EXC;
                    else
                        state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (qualified)
                    state_nxt = ST_WRITE;
                else if (expire)
                    state_nxt = ST_EXC;
            end
            ST_WRITE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_EXC:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MULT;
            wait_cnt <= '0;
            to_flag  <= 1'b0;
            unit_a   <= 32'd0;
            unit_b   <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        unit_a  <= op_a;
                        unit_b  <= op_b;
                        to_flag <= 1'b0;
                    end
                end
                ST_START: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (!qualified && expire)
                        to_flag <= 1'b1;
                end
                ST_WRITE: begin
                    case (op_q)
                        OP_DIV: begin
                            hi <= div_remainder;
                            lo <= div_quotient;
                        end
                        OP_MULT: begin
                            hi <= mult_hi;
                            lo <= mult_lo;
                        end
                        OP_MTHI: hi <= unit_a;
                        default: lo <= unit_a;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // All handshake outputs decode straight from the state register.
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE) || (state == ST_EXC);
    assign div_zero_exc = (state == ST_EXC) && !to_flag;
    assign timeout      = (state == ST_EXC) && to_flag;
    assign div_start    = (state == ST_START) && (op_q == OP_DIV);
    assign mult_start   = (state == ST_START) && (op_q == OP_MULT);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random operations against stub Div/Mult units
// and a cycle-level model of expected latency, flags and HI/LO contents.
module tb_muldiv_ctrl;

    localparam int SET = 1;
    localparam int TO  = 16;

    localparam logic [1:0] MULT = 2'b00;
    localparam logic [1:0] DIV  = 2'b01;
    localparam logic [1:0] MTHI = 2'b10;
    localparam logic [1:0] MTLO = 2'b11;

    logic        clock, reset, req;
    logic [1:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_zero_exc, timeout;
    logic [31:0] hi, lo, unit_a, unit_b;
    logic        div_start, mult_start;
    logic        div_finished, mult_done;
    logic [31:0] div_quotient, div_remainder, mult_hi, mult_lo;

    int checks = 0;
    int errors = 0;

    // Stub unit controls
    int  div_lat, mult_lat;
    bit  mult_never;
    int  div_cnt, mult_cnt;
    bit  mult_run;
    logic [31:0] mult_hi_v, mult_lo_v;
    logic [31:0] model_hi, model_lo;

    muldiv_ctrl #(.SETTLE(SET), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .timeout(timeout),
        .hi(hi), .lo(lo), .unit_a(unit_a), .unit_b(unit_b),
        .div_start(div_start), .mult_start(mult_start),
        .div_finished(div_finished), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Div stub: finished is combinational and high whenever it is not counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_cnt <= 0;
        else if (div_start) div_cnt <= div_lat;
        else if (div_cnt > 0) div_cnt <= div_cnt - 1;
    end
    assign div_finished = (div_cnt == 0);

    always_comb begin
        logic signed [31:0] sa, sb;
        sa = unit_a;
        sb = unit_b;
        div_quotient  = 32'd0;
        div_remainder = 32'd0;
        if (sb != 0 && !(sa == 32'sh80000000 && sb == -32'sd1)) begin
            div_quotient  = sa / sb;
            div_remainder = sa % sb;
        end
    end

    // Mult stub: done rises mult_lat cycles into WAIT and stays high until the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mult_cnt <= 0;
            mult_run <= 1'b0;
        end else if (mult_start) begin
            mult_cnt <= mult_lat;
            mult_run <= 1'b1;
        end else if (mult_cnt > 0) begin
            mult_cnt <= mult_cnt - 1;
        end
    end
    assign mult_done = mult_run && (mult_cnt == 0) && !mult_never;
    assign mult_hi   = mult_hi_v;
    assign mult_lo   = mult_lo_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check it against the model; poke pulses a stray req mid-operation.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit never, input bit poke);
        int exp_cyc, got_cyc, k, n_ds, n_ms;
        bit exp_dz, exp_to, got_dz, got_to, hold_bad;
        logic [31:0] eh, el, gh, gl;
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        eh = model_hi; el = model_lo;
        exp_dz = 0; exp_to = 0;
        k = (lat > SET) ? lat : SET;
        div_lat = lat; mult_lat = lat; mult_never = never;
        if (o == MTHI) begin
            exp_cyc = 2; eh = a;
        end else if (o == MTLO) begin
            exp_cyc = 2; el = a;
        end else if (o == DIV && b == 32'd0) begin
            exp_cyc = 1; exp_dz = 1;
        end else if ((o == MULT && never) || k >= TO) begin
            exp_cyc = 2 + TO; exp_to = 1;
        end else begin
            exp_cyc = 4 + k;
            if (o == DIV) begin
                el = sa / sb; eh = sa % sb;
            end else begin
                eh = mult_hi_v; el = mult_lo_v;
            end
        end

        @(negedge clock);
        req = 1'b1; op = o; op_a = a; op_b = b;
        got_cyc = -1; n_ds = 0; n_ms = 0; hold_bad = 0;
        got_dz = 0; got_to = 0; gh = '0; gl = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            req = poke && (c == 3);
            op = poke ? MTHI : $urandom_range(0, 3);
            op_a = $urandom; op_b = $urandom;
            n_ds += int'(div_start);
            n_ms += int'(mult_start);
            if (unit_a !== a || unit_b !== b || !busy) hold_bad = 1;
            if (done) begin
                got_cyc = c; got_dz = div_zero_exc; got_to = timeout; gh = hi; gl = lo;
                break;
            end
        end
        req = 1'b0;
        chk({nm, " latency"}, 64'(got_cyc), 64'(exp_cyc));
        chk({nm, " hi"}, 64'(gh), 64'(eh));
        chk({nm, " lo"}, 64'(gl), 64'(el));
        chk({nm, " dz/to"}, {62'd0, got_dz, got_to}, {62'd0, exp_dz, exp_to});
        chk({nm, " starts"}, {32'(n_ds), 32'(n_ms)},
            {32'((o == DIV && !exp_dz) ? 1 : 0), 32'((o == MULT) ? 1 : 0)});
        chk({nm, " operand hold"}, 64'(hold_bad), 64'd0);
        @(negedge clock);
        chk({nm, " idle after"}, {62'd0, busy, done}, 64'd0);
        if (poke) begin
            @(negedge clock);
            chk({nm, " stray req ignored"}, {31'd0, busy, hi}, {32'd0, eh});
        end
        model_hi = eh; model_lo = el;
    endtask

    initial begin
        req = 0; op = 0; op_a = 0; op_b = 0;
        div_lat = 0; mult_lat = 0; mult_never = 0;
        mult_hi_v = 0; mult_lo_v = 0;
        model_hi = 0; model_lo = 0;
        reset = 1'b1;
        #12;
        chk("reset outputs", {busy, done, div_zero_exc, timeout, div_start, mult_start}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset unit a/b", {unit_a, unit_b}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("div 100/7", DIV, 32'd100, 32'd7, 0, 0, 0);
        chk("div 100/7 values", {hi, lo}, {32'd2, 32'd14});
        run_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 3, 0, 0);
        chk("div -7/2 values", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        run_op("mthi 11", MTHI, 32'h11, 32'd0, 0, 0, 0);
        run_op("mtlo 22", MTLO, 32'h22, 32'd0, 0, 0, 0);
        run_op("div by zero", DIV, 32'd5, 32'd0, 0, 0, 0);
        chk("div by zero hi/lo", {hi, lo}, {32'h11, 32'h22});

        mult_hi_v = 32'h1; mult_lo_v = 32'hFFFFFFFE;
        run_op("mult stub", MULT, 32'hFFFFFFFF, 32'd2, 4, 0, 1);
        chk("mult values", {hi, lo}, {32'h1, 32'hFFFFFFFE});

        run_op("mthi dead", MTHI, 32'hDEADBEEF, 32'd0, 0, 0, 0);
        run_op("mtlo 1234", MTLO, 32'h12345678, 32'd0, 0, 0, 0);
        chk("mthi/mtlo final", {hi, lo}, {32'hDEADBEEF, 32'h12345678});

        mult_hi_v = 32'hAAAA5555; mult_lo_v = 32'h5555AAAA;
        run_op("mult never", MULT, 32'd3, 32'd4, 0, 1, 0);
        run_op("mult tie", MULT, 32'd3, 32'd4, TO - 1, 0, 0);
        run_op("div timeout", DIV, 32'd50, 32'd5, TO, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            mult_hi_v = $urandom; mult_lo_v = $urandom;
            run_op("random", o, a, b, $urandom_range(0, TO + 2), $urandom_range(0, 7) == 0, 0);
        end

        div_lat = 10;
        @(negedge clock);
        req = 1'b1; op = DIV; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async reset ctrl", {busy, done, div_zero_exc, timeout, div_start, mult_start}, 64'd0);
        chk("async reset hi/lo", {hi, lo}, 64'd0);
        chk("async reset unit", {unit_a, unit_b}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        model_hi = 0; model_lo = 0;
        run_op("div 9/3", DIV, 32'd9, 32'd3, 2, 0, 0);
        chk("div 9/3 values", {hi, lo}, {32'd0, 32'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
